// File: rtl/irq_controller.sv
// Wishbone interrupt controller: seven sources with pending/mask/mode
// registers and a fixed-priority vector presented to the CPU.
module irq_controller (
  input  logic        sysclock,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic [6:0]  irq_in,
  input  logic        int_en,
  output logic [2:0]  cpu_interrupt
);

  logic [6:0]  pend_q, pend_d;
  logic [6:0]  mask_q, mask_d;
  logic [6:0]  mode_q, mode_d;
  logic [6:0]  prev_q;
  logic [2:0]  irq_q, irq_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        req;
  logic        wr;
  logic [6:0]  clr;
  logic [6:0]  rise;
  logic [6:0]  drop;
  logic [6:0]  active;
  logic [6:0]  rd;
  logic [2:0]  vec;
  logic        unused;

  assign unused = ^{dat_i[31:7], sel_i[3:1]};

  assign req  = cyc_i & stb_i & ~ack_q;
  assign wr   = req & we_i & sel_i[0];
  assign ack_d = req;

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr) begin
      unique case (adr_i)
        2'd0: clr    = dat_i[6:0];
        2'd1: mask_d = dat_i[6:0];
        2'd2: mode_d = dat_i[6:0];
        default: ;
      endcase
    end
  end

  // edge bits switched back to level drop any latched edge
  assign rise = irq_in & ~prev_q;
  assign drop = mode_q & ~mode_d;

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < 7; i++) begin
      if (drop[i])
        pend_d[i] = 1'b0;
      else if (mode_q[i])
        pend_d[i] = (pend_q[i] & ~clr[i]) | rise[i];
      else
        pend_d[i] = irq_in[i];
    end
  end

  assign active = pend_q & mask_q;

  always_comb begin
    vec = 3'd0;
    if (active[6])      vec = 3'd1;
    else if (active[5]) vec = 3'd5;
    else if (active[4]) vec = 3'd4;
    else if (active[3]) vec = 3'd3;
    else if (active[2]) vec = 3'd2;
    else if (active[1]) vec = 3'd6;
    else if (active[0]) vec = 3'd7;
    irq_d = int_en ? vec : 3'd0;
  end

  always_comb begin
    rd = '0;
    unique case (adr_i)
      2'd0: rd = pend_q;
      2'd1: rd = mask_q;
      2'd2: rd = mode_q;
      2'd3: rd = {4'd0, irq_q};
      default: rd = '0;
    endcase
    dat_d = ack_d ? {25'd0, rd} : 32'd0;
  end

  always_ff @(posedge sysclock or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      mask_q <= 7'h40;
      mode_q <= '0;
      prev_q <= '0;
      irq_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      prev_q <= irq_in;
      irq_q  <= irq_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
  end

  assign ack_o         = ack_q;
  assign dat_o         = dat_q;
  assign cpu_interrupt = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: registers, priority,
// edge/level pending, ack handshake and async reset.
module tb_irq_controller;

  logic        sysclock = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [6:0]  irq_in = '0;
  logic        int_en = 1'b0;
  logic [2:0]  cpu_interrupt;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;

  irq_controller dut (
    .sysclock(sysclock),
    .rst_i(rst_i),
    .cyc_i(cyc_i),
    .stb_i(stb_i),
    .we_i(we_i),
    .adr_i(adr_i),
    .dat_i(dat_i),
    .sel_i(sel_i),
    .dat_o(dat_o),
    .ack_o(ack_o),
    .irq_in(irq_in),
    .int_en(int_en),
    .cpu_interrupt(cpu_interrupt)
  );

  always #5 sysclock = ~sysclock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge sysclock);
  endtask

  // ends on the ack cycle; caller idles before the next access
  task automatic wb_write(input logic [1:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = a; dat_i = d; sel_i = s;
    @(negedge sysclock);
    check("wr_ack", {31'd0, ack_o}, 32'd1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    adr_i = a; sel_i = 4'hF;
    @(negedge sysclock);
    check("rd_ack", {31'd0, ack_o}, 32'd1);
    d = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; sel_i = '0;
    @(negedge sysclock);
  endtask

  initial begin
    #12;
    check("rst_vec", {29'd0, cpu_interrupt}, 32'd0);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    @(negedge sysclock);
    rst_i = 1'b0;

    // only the MMU fault is unmasked out of reset
    int_en = 1'b1;
    irq_in = 7'h7F;
    @(negedge sysclock);
    check("mmu_lat1", {29'd0, cpu_interrupt}, 32'd0);
    @(negedge sysclock);
    check("mmu_vec", {29'd0, cpu_interrupt}, 32'd1);
    wb_read(2'd0, rd);
    check("mmu_pend", rd, 32'h7F);
    irq_in = 7'h00;
    tick(2);
    check("mmu_off", {29'd0, cpu_interrupt}, 32'd0);

    // edge source 5
    wb_write(2'd1, 32'h7F, 4'h1);
    tick(1);
    wb_write(2'd2, 32'h20, 4'h1);
    tick(1);
    irq_in = 7'h20;
    @(negedge sysclock);
    irq_in = 7'h00;
    check("e5_lat1", {29'd0, cpu_interrupt}, 32'd0);
    @(negedge sysclock);
    check("e5_vec", {29'd0, cpu_interrupt}, 32'd5);
    tick(3);
    check("e5_hold", {29'd0, cpu_interrupt}, 32'd5);
    wb_read(2'd0, rd);
    check("e5_pend", rd, 32'h20);
    wb_write(2'd0, 32'h20, 4'h1);
    check("e5_clr_lat", {29'd0, cpu_interrupt}, 32'd5);
    @(negedge sysclock);
    check("e5_clr", {29'd0, cpu_interrupt}, 32'd0);

    // set beats clear on bit 3
    wb_write(2'd2, 32'h28, 4'h1);
    tick(1);
    irq_in = 7'h08;
    wb_write(2'd0, 32'h08, 4'h1);
    irq_in = 7'h00;
    tick(1);
    wb_read(2'd0, rd);
    check("e3_setwin", rd, 32'h08);
    check("e3_vec", {29'd0, cpu_interrupt}, 32'd3);
    wb_write(2'd0, 32'h08, 4'h1);
    tick(1);
    wb_read(2'd0, rd);
    check("e3_clr", rd, 32'h00);

    // mode 1->0 drops latched edge
    irq_in = 7'h20;
    @(negedge sysclock);
    irq_in = 7'h00;
    @(negedge sysclock);
    check("md_vec", {29'd0, cpu_interrupt}, 32'd5);
    wb_write(2'd2, 32'h00, 4'h1);
    @(negedge sysclock);
    check("md_drop", {29'd0, cpu_interrupt}, 32'd0);

    // level sources 1 and 2
    irq_in = 7'h06;
    tick(2);
    check("lv_vec2", {29'd0, cpu_interrupt}, 32'd2);
    irq_in = 7'h02;
    @(negedge sysclock);
    check("lv_lat", {29'd0, cpu_interrupt}, 32'd2);
    @(negedge sysclock);
    check("lv_vec6", {29'd0, cpu_interrupt}, 32'd6);
    int_en = 1'b0;
    @(negedge sysclock);
    check("lv_inten", {29'd0, cpu_interrupt}, 32'd0);
    wb_read(2'd0, rd);
    check("lv_pend", rd, 32'h02);
    wb_read(2'd3, rd);
    check("lv_vreg", rd, 32'h0);

    // continuous strobe on VECTOR
    int_en = 1'b1;
    irq_in = 7'h10;
    tick(2);
    check("v4_vec", {29'd0, cpu_interrupt}, 32'd4);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd3;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge sysclock);
      check($sformatf("hold_ack%0d", i), {31'd0, ack_o}, 32'(i % 2));
      check($sformatf("hold_dat%0d", i), dat_o, (i % 2) ? 32'd4 : 32'd0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    tick(1);
    wb_write(2'd1, 32'h00, 4'b1110);
    tick(1);
    wb_read(2'd1, rd);
    check("sel_mask", rd, 32'h7F);

    // async reset mid-ack, held strobe acked after release
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd3;
    @(negedge sysclock);
    check("ar_ack", {31'd0, ack_o}, 32'd1);
    check("ar_vec", {29'd0, cpu_interrupt}, 32'd4);
    #2 rst_i = 1'b1;
    #1;
    check("ar_ack0", {31'd0, ack_o}, 32'd0);
    check("ar_vec0", {29'd0, cpu_interrupt}, 32'd0);
    check("ar_dat0", dat_o, 32'd0);
    @(negedge sysclock);
    rst_i = 1'b0;
    check("ar_rel", {31'd0, ack_o}, 32'd0);
    @(negedge sysclock);
    check("ar_reack", {31'd0, ack_o}, 32'd1);
    cyc_i = 1'b0; stb_i = 1'b0;
    tick(1);
    wb_read(2'd1, rd);
    check("ar_mask", rd, 32'h40);
    wb_read(2'd2, rd);
    check("ar_mode", rd, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
